// File: rtl/micro_sequencer.sv
// micro_sequencer: generates the micro-address and latched operands for
// control_unit. It runs the fetch routine, dispatches on the opcode and then
// steps through that opcode's micro-routine.
// Optional wait-state watchdog (mem_err port): define MICROSEQ_WAIT_WATCHDOG_EN.
module micro_sequencer #(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        hit,
    input  logic        zero,
    input  logic [15:0] ins_in,
    output logic [8:0]  addr_ins,
    output logic [3:0]  operand1,
    output logic [3:0]  operand2,
    output logic        instr_done,
    output logic        illegal,
`ifdef MICROSEQ_WAIT_WATCHDOG_EN
    output logic        halted,
    output logic        mem_err
`else
    output logic        halted
`endif
);

    typedef enum logic [3:0] {
        S_FETCH1, S_FETCH_WAIT, S_FETCH_FIN1, S_FETCH_FIN2, S_INCPC,
        S_STEP,
        S_LOAD1, S_LOAD_WAIT, S_LOAD2, S_LOAD3, S_LOAD4,
        S_GOTOZ1, S_GOTOZ2, S_GOTOZ3,
        S_HALT
    } state_t;

    localparam logic [4:0] OP_LOAD  = 5'b11100;
    localparam logic [4:0] OP_GOTOZ = 5'b10110;
    localparam logic [4:0] OP_HALT  = 5'b11111;

    // Number of steps of a plain stepped routine; 0 marks an unknown opcode.
    function automatic logic [2:0] route_len(input logic [4:0] op);
        case (op)
            5'b11010, 5'b01010, 5'b11001, 5'b01011, 5'b00011,
            5'b00101, 5'b00100, 5'b10100, 5'b10101: route_len = 3'd2;
            5'b01101:                               route_len = 3'd1;
            5'b11011:                               route_len = 3'd3;
            5'b10001, 5'b10010, 5'b11101:           route_len = 3'd4;
            default:                                route_len = 3'd0;
        endcase
    endfunction

    // Micro-address presented while in a given state.
    function automatic logic [8:0] addr_of(input state_t s, input logic [2:0] stp,
                                           input logic [4:0] op);
        case (s)
            S_FETCH1:     addr_of = 9'h000;
            S_FETCH_WAIT: addr_of = 9'h002;
            S_FETCH_FIN1: addr_of = 9'h102;
            S_FETCH_FIN2: addr_of = 9'h103;
            S_INCPC:      addr_of = 9'h001;
            S_STEP:       addr_of = {1'b0, op, stp};
            S_LOAD1:      addr_of = 9'h0E0;
            S_LOAD_WAIT:  addr_of = 9'h0E6;
            S_LOAD2:      addr_of = 9'h1E6;
            S_LOAD3:      addr_of = 9'h0E2;
            S_LOAD4:      addr_of = 9'h0E3;
            S_GOTOZ1:     addr_of = 9'h0B0;
            S_GOTOZ2:     addr_of = 9'h0B1;
            S_GOTOZ3:     addr_of = 9'h1B1;
            S_HALT:       addr_of = 9'h0FF;
            default:      addr_of = 9'h000;
        endcase
    endfunction

    state_t     state, state_n;
    logic [2:0] step, step_n;
    logic [4:0] op_q;
    logic [2:0] cur_len;
    logic       done_n;
    logic       illegal_n;
    logic       latch_ins;
    logic       in_wait;
    logic       wait_timeout;
    logic       unused_ins_hi;

    assign unused_ins_hi = ^ins_in[15:13];
    assign cur_len       = route_len(op_q);
    assign in_wait       = (state == S_FETCH_WAIT) || (state == S_LOAD_WAIT);

`ifdef MICROSEQ_WAIT_WATCHDOG_EN
    localparam int unsigned CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;

    logic [CNT_W-1:0] wait_cnt;

    assign wait_timeout = in_wait && !hit && ((32'(wait_cnt) + 32'd1) >= WAIT_LIMIT);

    // Wait-state counter and sticky memory error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else if (en) begin
            if (state == S_FETCH1 || state == S_LOAD1)
                wait_cnt <= '0;
            else if (in_wait && !hit)
                wait_cnt <= wait_cnt + 1'b1;
            if (wait_timeout)
                mem_err <= 1'b1;
        end
    end
`else
    localparam int unsigned WAIT_LIMIT_UNUSED = WAIT_LIMIT;

    assign wait_timeout = 1'b0;
`endif

    // Next-state, next-step and flag decode.
    always_comb begin
        state_n   = state;
        step_n    = step;
        done_n    = 1'b0;
        illegal_n = illegal;
        latch_ins = 1'b0;
        case (state)
            S_FETCH1:     state_n = S_FETCH_WAIT;
            S_FETCH_WAIT: begin
                if (hit)               state_n = S_FETCH_FIN1;
                else if (wait_timeout) state_n = S_HALT;
            end
            S_FETCH_FIN1: state_n = S_FETCH_FIN2;
            S_FETCH_FIN2: begin
                state_n   = S_INCPC;
                latch_ins = 1'b1;
            end
            S_INCPC: begin
                case (op_q)
                    OP_LOAD:  state_n = S_LOAD1;
                    OP_GOTOZ: state_n = S_GOTOZ1;
                    OP_HALT: begin
                        state_n = S_HALT;
                        done_n  = 1'b1;
                    end
                    default: begin
                        if (cur_len == 3'd0) begin
                            state_n   = S_FETCH1;
                            illegal_n = 1'b1;
                        end else begin
                            state_n = S_STEP;
                            step_n  = 3'd0;
                            done_n  = (cur_len == 3'd1);
                        end
                    end
                endcase
            end
            S_STEP: begin
                if (step == cur_len - 3'd1) begin
                    state_n = S_FETCH1;
                end else begin
                    step_n = step + 3'd1;
                    done_n = ((step + 3'd1) == (cur_len - 3'd1));
                end
            end
            S_LOAD1:      state_n = S_LOAD_WAIT;
            S_LOAD_WAIT: begin
                if (hit)               state_n = S_LOAD2;
                else if (wait_timeout) state_n = S_HALT;
            end
            S_LOAD2:      state_n = S_LOAD3;
            S_LOAD3: begin
                state_n = S_LOAD4;
                done_n  = 1'b1;
            end
            S_LOAD4:      state_n = S_FETCH1;
            S_GOTOZ1: begin
                state_n = zero ? S_GOTOZ2 : S_GOTOZ3;
                done_n  = 1'b1;
            end
            S_GOTOZ2:     state_n = S_FETCH1;
            S_GOTOZ3:     state_n = S_FETCH1;
            S_HALT:       state_n = S_HALT;
            default:      state_n = S_FETCH1;
        endcase
    end

    // State register and registered outputs; en=0 freezes everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_FETCH1;
            step       <= 3'd0;
            op_q       <= '0;
            operand1   <= '0;
            operand2   <= '0;
            addr_ins   <= 9'h000;
            instr_done <= 1'b0;
            illegal    <= 1'b0;
            halted     <= 1'b0;
        end else if (en) begin
            state      <= state_n;
            step       <= step_n;
            addr_ins   <= addr_of(state_n, step_n, op_q);
            instr_done <= done_n;
            illegal    <= illegal_n;
            halted     <= (state_n == S_HALT);
            if (latch_ins) begin
                op_q     <= ins_in[12:8];
                operand1 <= ins_in[7:4];
                operand2 <= ins_in[3:0];
            end
        end else begin
            instr_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Testbench for micro_sequencer: a trace model builds the expected
// micro-address sequence of each instruction and a negedge process compares.
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        hit = 1'b0;
    logic        zero = 1'b0;
    logic [15:0] ins_in = '0;
    logic [8:0]  addr_ins;
    logic [3:0]  operand1, operand2;
    logic        instr_done, illegal, halted;

    always #5 clk = ~clk;

`ifdef MICROSEQ_WAIT_WATCHDOG_EN
    logic mem_err;
    micro_sequencer #(.WAIT_LIMIT(8)) dut (
        .clk(clk), .reset(reset), .en(en), .hit(hit), .zero(zero), .ins_in(ins_in),
        .addr_ins(addr_ins), .operand1(operand1), .operand2(operand2),
        .instr_done(instr_done), .illegal(illegal), .halted(halted), .mem_err(mem_err)
    );
`else
    micro_sequencer dut (
        .clk(clk), .reset(reset), .en(en), .hit(hit), .zero(zero), .ins_in(ins_in),
        .addr_ins(addr_ins), .operand1(operand1), .operand2(operand2),
        .instr_done(instr_done), .illegal(illegal), .halted(halted)
    );
`endif

    typedef struct packed {
        logic       en;
        logic       hit;
        logic       zero;
        logic [8:0] addr;
        logic       done;
        logic [3:0] op1;
        logic [3:0] op2;
        logic       ill;
        logic       hlt;
    } ent_t;

    localparam logic [8:0] NO_ABORT = 9'h1FF;

    int errors = 0;
    int checks = 0;

    ent_t       tr[$];
    ent_t       exp_q[$];
    ent_t       cur;
    logic [8:0] cap_q[$];
    logic [8:0] lit[$];
    logic [3:0] m_op1 = '0;
    logic [3:0] m_op2 = '0;
    logic       m_ill = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // Routine lengths of the plain stepped opcodes (0 = not a plain routine).
    function automatic int rlen(input logic [4:0] op);
        case (op)
            5'b11010, 5'b01010, 5'b11001, 5'b01011, 5'b00011,
            5'b00101, 5'b00100, 5'b10100, 5'b10101: rlen = 2;
            5'b01101:                               rlen = 1;
            5'b11011:                               rlen = 3;
            5'b10001, 5'b10010, 5'b11101:           rlen = 4;
            default:                                rlen = 0;
        endcase
    endfunction

    task automatic add(input logic e, input logic h, input logic z,
                       input logic [8:0] a, input logic d);
        ent_t x;
        x.en = e; x.hit = h; x.zero = z; x.addr = a; x.done = d;
        x.op1 = m_op1; x.op2 = m_op2; x.ill = m_ill; x.hlt = (a == 9'h0FF);
        tr.push_back(x);
    endtask

    // Expected per-cycle trace of one instruction starting from FETCH1.
    // Each entry: inputs for a cycle and the outputs after that cycle's edge.
    task automatic build(input logic [15:0] ins, input int fw, input int lw,
                         input logic z, input int halt_hold);
        logic [4:0] op;
        int len;
        op = ins[12:8];
        tr.delete();
        add(1'b1, 1'b0, z, 9'h002, 1'b0);
        repeat (fw) add(1'b1, 1'b0, z, 9'h002, 1'b0);
        add(1'b1, 1'b1, z, 9'h102, 1'b0);
        add(1'b1, 1'b0, z, 9'h103, 1'b0);
        m_op1 = ins[7:4];
        m_op2 = ins[3:0];
        add(1'b1, 1'b0, z, 9'h001, 1'b0);
        case (op)
            5'b11100: begin
                add(1'b1, 1'b0, z, 9'h0E0, 1'b0);
                add(1'b1, 1'b0, z, 9'h0E6, 1'b0);
                repeat (lw) add(1'b1, 1'b0, z, 9'h0E6, 1'b0);
                add(1'b1, 1'b1, z, 9'h1E6, 1'b0);
                add(1'b1, 1'b0, z, 9'h0E2, 1'b0);
                add(1'b1, 1'b0, z, 9'h0E3, 1'b1);
                add(1'b1, 1'b0, z, 9'h000, 1'b0);
            end
            5'b10110: begin
                add(1'b1, 1'b0, z, 9'h0B0, 1'b0);
                add(1'b1, 1'b0, z, z ? 9'h0B1 : 9'h1B1, 1'b1);
                add(1'b1, 1'b0, z, 9'h000, 1'b0);
            end
            5'b11111: begin
                add(1'b1, 1'b0, z, 9'h0FF, 1'b1);
                repeat (halt_hold) add(1'b1, 1'($urandom_range(0, 1)), z, 9'h0FF, 1'b0);
            end
            default: begin
                len = rlen(op);
                if (len == 0) begin
                    m_ill = 1'b1;
                end else begin
                    for (int k = 0; k < len; k++)
                        add(1'b1, 1'b0, z, {1'b0, op, 3'(k)}, (k == len - 1));
                end
                add(1'b1, 1'b0, z, 9'h000, 1'b0);
            end
        endcase
    endtask

    // Insert n frozen cycles (en=0, hit=h) after the first entry at address 'at'.
    task automatic add_stall(input logic [8:0] at, input int n, input logic h);
        ent_t src[$];
        ent_t s;
        bit done_ins;
        src = tr;
        tr.delete();
        done_ins = 1'b0;
        foreach (src[i]) begin
            tr.push_back(src[i]);
            if (src[i].addr == at && !done_ins) begin
                done_ins = 1'b1;
                s = src[i];
                s.en = 1'b0; s.hit = h; s.done = 1'b0;
                repeat (n) tr.push_back(s);
            end
        end
    endtask

    task automatic run_trace(input logic [15:0] ins, input logic [8:0] abort_at);
        ins_in = ins;
        cap_q.delete();
        foreach (tr[i]) begin
            en = tr[i].en; hit = tr[i].hit; zero = tr[i].zero;
            @(posedge clk);
            #1;
            exp_q.push_back(tr[i]);
            if (abort_at != NO_ABORT && tr[i].addr == abort_at) break;
        end
        en = 1'b1;
        hit = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic check_tail(input string name);
        chk({name, "_len"}, 32'(cap_q.size() >= lit.size()), 32'd1);
        if (cap_q.size() >= lit.size())
            for (int i = 0; i < lit.size(); i++)
                chk(name, 32'(cap_q[cap_q.size() - lit.size() + i]), 32'(lit[i]));
    endtask

    task automatic check_cleared(input string name);
        chk({name, "_addr"}, 32'(addr_ins), 32'h000);
        chk({name, "_op1"}, 32'(operand1), 32'd0);
        chk({name, "_op2"}, 32'(operand2), 32'd0);
        chk({name, "_done"}, 32'(instr_done), 32'd0);
        chk({name, "_illegal"}, 32'(illegal), 32'd0);
        chk({name, "_halted"}, 32'(halted), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        exp_q.delete();
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_op1 = '0; m_op2 = '0; m_ill = 1'b0;
    endtask

    // Per-cycle comparison against the model trace.
    always @(negedge clk) begin
        if (reset) cap_q.push_back(addr_ins);
        if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            chk("addr_ins", 32'(addr_ins), 32'(cur.addr));
            chk("instr_done", 32'(instr_done), 32'(cur.done));
            chk("operand1", 32'(operand1), 32'(cur.op1));
            chk("operand2", 32'(operand2), 32'(cur.op2));
            chk("illegal", 32'(illegal), 32'(cur.ill));
            chk("halted", 32'(halted), 32'(cur.hlt));
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [15:0] misc [6];
        misc = '{16'h1A00, 16'h0D21, 16'h1B46, 16'h1D00, 16'h1200, 16'h0300};

        #2 reset = 1'b0;
        #1 check_cleared("reset");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        // ADD with two extra fetch wait cycles
        build(16'h0A35, 2, 0, 1'b0, 0);
        run_trace(16'h0A35, NO_ABORT);
        lit = '{9'h002, 9'h002, 9'h002, 9'h102, 9'h103, 9'h001, 9'h050, 9'h051, 9'h000};
        check_tail("add_seq");
        chk("add_op1", 32'(operand1), 32'd3);
        chk("add_op2", 32'(operand2), 32'd5);

        // LOAD with four wait cycles
        build(16'h1C12, 0, 4, 1'b0, 0);
        run_trace(16'h1C12, NO_ABORT);
        lit = '{9'h0E0, 9'h0E6, 9'h0E6, 9'h0E6, 9'h0E6, 9'h0E6, 9'h1E6, 9'h0E2, 9'h0E3, 9'h000};
        check_tail("load_seq");

        // LOAD where hit arrives while en is low in the wait state
        build(16'h1C12, 1, 2, 1'b0, 0);
        add_stall(9'h0E6, 2, 1'b1);
        run_trace(16'h1C12, NO_ABORT);

        // GOTOZ both branch directions
        build(16'h1647, 0, 0, 1'b1, 0);
        run_trace(16'h1647, NO_ABORT);
        lit = '{9'h0B0, 9'h0B1, 9'h000};
        check_tail("gotoz_taken");
        build(16'h1647, 0, 0, 1'b0, 0);
        run_trace(16'h1647, NO_ABORT);
        lit = '{9'h0B0, 9'h1B1, 9'h000};
        check_tail("gotoz_not");

        // Other routine lengths (1, 2, 3, 4 steps)
        foreach (misc[i]) begin
            build(misc[i], i % 2, 0, 1'b0, 0);
            run_trace(misc[i], NO_ABORT);
        end

        // Unknown opcode, then HALT with hit toggling
        build(16'h0700, 0, 0, 1'b0, 0);
        run_trace(16'h0700, NO_ABORT);
        lit = '{9'h001, 9'h000};
        check_tail("illegal_seq");
        chk("illegal_set", 32'(illegal), 32'd1);
        build(16'h1F00, 0, 0, 1'b0, 20);
        run_trace(16'h1F00, NO_ABORT);
        chk("halt_addr", 32'(addr_ins), 32'h0FF);
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_illegal_sticky", 32'(illegal), 32'd1);
        do_reset();

        // ADDL with en low for three cycles at 089
        build(16'h1100, 0, 0, 1'b0, 0);
        add_stall(9'h089, 3, 1'b0);
        run_trace(16'h1100, NO_ABORT);
        lit = '{9'h088, 9'h089, 9'h089, 9'h089, 9'h089, 9'h08A, 9'h08B, 9'h000};
        check_tail("addl_stall");

        // Illegal flag set, then reset asserted mid-ADDL at 08A
        build(16'h0000, 0, 0, 1'b0, 0);
        run_trace(16'h0000, NO_ABORT);
        build(16'h1198, 0, 0, 1'b0, 0);
        run_trace(16'h1198, 9'h08A);
        chk("pre_reset_addr", 32'(addr_ins), 32'h08A);
        reset = 1'b0;
        exp_q.delete();
        #1 check_cleared("async_reset");
        @(posedge clk);
        #1 reset = 1'b1;
        m_op1 = '0; m_op2 = '0; m_ill = 1'b0;

        // Recovery after reset
        build(16'h0D21, 0, 0, 1'b0, 0);
        run_trace(16'h0D21, NO_ABORT);
        lit = '{9'h068, 9'h000};
        check_tail("incacc_seq");

`ifdef MICROSEQ_WAIT_WATCHDOG_EN
        do_reset();
        en = 1'b1;
        hit = 1'b0;
        ins_in = '0;
        repeat (8) @(posedge clk);
        #1;
        chk("wd_before_addr", 32'(addr_ins), 32'h002);
        chk("wd_before_err", 32'(mem_err), 32'd0);
        @(posedge clk);
        #1;
        chk("wd_addr", 32'(addr_ins), 32'h0FF);
        chk("wd_mem_err", 32'(mem_err), 32'd1);
        chk("wd_halted", 32'(halted), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Upstream stage of control_unit: generates the 9-bit micro-address (addr_ins) plus operand1/operand2 that control_unit decodes into the 39-bit control word.
- Runs the fetch micro-routine, latches the instruction, dispatches to the opcode's micro-routine and steps through it.
- Handles memory wait states (hit) and the GOTOZ branch, then returns to fetch.
- Updates on posedge clk; control_unit samples on negedge, so outputs are stable half a cycle before use.

Parameters:
- WAIT_LIMIT, 255: wait-state watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  input  1  system clock, posedge.
- reset  input  1  asynchronous, active-low; low forces the reset state immediately.
- en  input  1  advance enable; low freezes all state and outputs.
- hit  input  1  memory/cache ready, sampled in wait states.
- zero  input  1  accumulator zero flag, sampled in GOTOZ1.
- ins_in  input  16  instruction word from memory data path: [12:8] opcode, [7:4] op1, [3:0] op2; [15:13] ignored.
- addr_ins  output  9  micro-address {variant[8], opcode[7:3], step[2:0]}.
- operand1  output  4  latched op1.
- operand2  output  4  latched op2.
- instr_done  output  1  one-cycle pulse on the last micro-step of a non-fetch routine.
- illegal  output  1  sticky flag: unknown opcode decoded.
- halted  output  1  high while in HALT.

Behaviour:
- All outputs registered. Reset values: addr_ins=9'h000 (FETCH1), operand1=0, operand2=0, instr_done=0, illegal=0, halted=0. Internal instruction latch is also cleared.
- Every transition below requires en=1. With en=0, state holds and instr_done=0.
- Fetch sequence:
  - FETCH1 000000000 -> FETCH_WAIT 000000010.
  - FETCH_WAIT holds while hit=0; -> FETCH_FINISH1 100000010 when hit=1.
  - FETCH_FINISH1 -> FETCH_FINISH2 100000011.
  - ins_in is latched on the clock edge leaving FETCH_FINISH2; operand1/operand2 update on that same edge.
  - FETCH_FINISH2 -> INCPC 000000001 -> dispatch.
- Dispatch: addr_ins = {1'b0, opcode, 3'b000}. Any unlisted opcode sets illegal and goes to FETCH1.
- Routine step counts (each step 1 cycle; step field increments; leaving the last step -> FETCH1 with instr_done pulse):
  - 2 steps: CLRREG 11010, ADD 01010, ADDI 11001, SUBI 01011, INC128 00011, CPYREG 00101, CPYACC 00100, SHFLI 10100, SHFRI 10101.
  - 1 step: INCACC 01101.
  - 3 steps: LOD128 11011.
  - 4 steps: ADDL 10001, ADDH 10010, STORE 11101.
- LOAD (11100):
  - LOAD1 011100000 -> LOAD_WAIT 011100110.
  - LOAD_WAIT holds while hit=0; -> LOAD2 111100110 on hit.
  - LOAD2 -> LOAD3 011100010 -> LOAD4 011100011 (last step).
- GOTOZ (10110):
  - GOTOZ1 010110000; zero sampled on the edge leaving it.
  - zero=1 -> GOTOZ2 010110001; zero=0 -> GOTOZ3 110110001. Both are last steps.
- HALT (11111): addr_ins=011111111, halted=1, no further transitions until reset; instr_done pulses once on entry.
- Simultaneous events:
  - en=0 with hit=1 in a wait state: hit is ignored that cycle.
  - reset asserted mid-routine: immediate return to FETCH1 and outputs cleared.
  - illegal clears only on reset.

Optional Feature:
- Macro MICROSEQ_WAIT_WATCHDOG_EN.
- Defined:
  - Adds output mem_err (1 bit, reset 0, sticky) and a wait counter.
  - The counter clears on entry to FETCH_WAIT or LOAD_WAIT and increments each en=1 cycle spent there with hit=0.
  - When the count reaches WAIT_LIMIT, mem_err is set and the next state is HALT.
- Undefined: no mem_err port or counter; wait states hold indefinitely.

Test Plan:
- Reset, then hit=1 on the 3rd FETCH_WAIT cycle, ins_in=16'h0A35 (ADD, op1=3, op2=5) -> addr_ins 000,002,002,002,102,103,001,050,051,000; operand1=3, operand2=5; instr_done high during 051.
- LOAD, ins_in=16'h1C12, hit held 0 for 4 cycles in LOAD_WAIT -> 0E0, 0E6 for 5 cycles, 1E6, 0E2, 0E3, 000.
- GOTOZ ins_in=16'h1647: zero=1 -> 0B0, 0B1; repeat with zero=0 -> 0B0, 1B1.
- Opcode 5'b00111 -> illegal=1, next addr_ins=000; then HALT 16'h1F00 -> addr_ins=0FF, halted=1 held 20 cycles despite hit toggling.
- Assert reset mid-ADDL (at 08A) -> addr_ins=000 and all flags 0 asynchronously. en=0 for 3 cycles at 089 -> addr_ins stays 089.
- With MICROSEQ_WAIT_WATCHDOG_EN and WAIT_LIMIT=8, hit held 0 in FETCH_WAIT -> mem_err=1 and addr_ins=0FF after 8 cycles.
